// File: rtl/sad_disp_search.sv
// Minimum-SAD disparity search, DISP_THREADS candidates per cycle; result N+1 cycles after accept.
// in_ready is low while searching or holding a result; the result is held until out_ready.
module sad_disp_search #(
    parameter int WIN          = 15,
    parameter int DATA_SIZE    = 8,
    parameter int MAX_DISP     = 64,
    parameter int DISP_THREADS = 16,
    parameter int EARLY_EXIT   = 0,
    localparam int G         = MAX_DISP / DISP_THREADS,
    localparam int STRIP_W   = WIN + MAX_DISP - 1,
    localparam int SAD_BITS  = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1),
    localparam int DISP_BITS = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1,
    localparam int GRP_BITS  = (G > 1) ? $clog2(G) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_SIZE*WIN*WIN-1:0]      win_l,
    input  logic [DATA_SIZE*WIN*STRIP_W-1:0]  strip_r,
    input  logic [DISP_BITS-1:0]              disp_limit,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DISP_BITS-1:0]              out_disp,
    output logic [SAD_BITS-1:0]               out_sad
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [DATA_SIZE*WIN*WIN-1:0]     r_win;
    logic [DATA_SIZE*WIN*STRIP_W-1:0] r_strip;
    logic [DISP_BITS-1:0]             r_limit;
    logic [GRP_BITS-1:0]              r_grp;
    logic [GRP_BITS-1:0]              r_last_grp;
    logic [SAD_BITS-1:0]              r_best_sad;
    logic [DISP_BITS-1:0]             r_best_disp;
    logic                             r_out_vld;
    logic [DISP_BITS-1:0]             r_out_disp;
    logic [SAD_BITS-1:0]              r_out_sad;

    logic                             w_accept;
    logic [DISP_BITS-1:0]             w_lim;
    logic [GRP_BITS-1:0]              w_last_grp;
    logic [SAD_BITS-1:0]              w_sad [DISP_THREADS];
    logic                             w_cand_found;
    logic [SAD_BITS-1:0]              w_cand_sad;
    logic [DISP_BITS-1:0]             w_cand_disp;
    logic [SAD_BITS-1:0]              w_nb_sad;
    logic [DISP_BITS-1:0]             w_nb_disp;
    logic                             w_finish;

    function automatic logic [DATA_SIZE-1:0] absdiff(input logic [DATA_SIZE-1:0] a,
                                                     input logic [DATA_SIZE-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_vld;
    assign out_disp  = r_out_disp;
    assign out_sad   = r_out_sad;

    // Limits beyond the last candidate search the whole range.
    always_comb begin
        w_lim = disp_limit;
        if (int'(disp_limit) > MAX_DISP - 1)
            w_lim = DISP_BITS'(MAX_DISP - 1);
        w_last_grp = GRP_BITS'(int'(w_lim) / DISP_THREADS);
    end

    always_comb begin
        for (int t = 0; t < DISP_THREADS; t++) begin
            w_sad[t] = '0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    w_sad[t] = w_sad[t] + SAD_BITS'(absdiff(
                        r_win[DATA_SIZE*(r*WIN+c) +: DATA_SIZE],
                        r_strip[DATA_SIZE*(r*STRIP_W+c+int'(r_grp)*DISP_THREADS+t) +: DATA_SIZE]));
                end
            end
        end
    end

    // Strict compares in ascending t keep the lowest disparity on ties.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_sad   = '1;
        w_cand_disp  = '0;
        for (int t = 0; t < DISP_THREADS; t++) begin
            if ((int'(r_grp) * DISP_THREADS + t <= int'(r_limit)) &&
                (!w_cand_found || (w_sad[t] < w_cand_sad))) begin
                w_cand_found = 1'b1;
                w_cand_sad   = w_sad[t];
                w_cand_disp  = DISP_BITS'(int'(r_grp) * DISP_THREADS + t);
            end
        end
        w_nb_sad  = r_best_sad;
        w_nb_disp = r_best_disp;
        if (w_cand_found && (w_cand_sad < r_best_sad)) begin
            w_nb_sad  = w_cand_sad;
            w_nb_disp = w_cand_disp;
        end
        w_finish = (r_grp == r_last_grp) || ((EARLY_EXIT != 0) && (w_nb_sad == '0));
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                if (w_finish)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld   <= 1'b0;
            r_out_disp  <= '0;
            r_out_sad   <= '0;
            r_grp       <= '0;
            r_best_sad  <= '1;
            r_best_disp <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grp       <= '0;
                        r_best_sad  <= '1;
                        r_best_disp <= '0;
                    end
                end
                S_SEARCH: begin
                    r_best_sad  <= w_nb_sad;
                    r_best_disp <= w_nb_disp;
                    if (w_finish) begin
                        r_out_vld  <= 1'b1;
                        r_out_disp <= w_nb_disp;
                        r_out_sad  <= w_nb_sad;
                    end else begin
                        r_grp <= r_grp + GRP_BITS'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_out_vld <= 1'b0;
                end
                default: r_out_vld <= 1'b0;
            endcase
        end
    end

    // Captured request payload; needs no reset since it is only read in SEARCH.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win      <= win_l;
            r_strip    <= strip_r;
            r_limit    <= w_lim;
            r_last_grp <= w_last_grp;
        end
    end

endmodule

// File: tb/tb_sad_disp_search.sv
module tb_sad_disp_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, out_ready;
    logic [71:0]  win_l;
    logic [239:0] strip_r;
    logic [2:0]   disp_limit;

    logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [2:0]   a_out_disp, b_out_disp;
    logic [11:0]  a_out_sad, b_out_sad;

    logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1799:0] c_win;
    logic [9359:0] c_strip;
    logic [5:0]    c_limit, c_out_disp;
    logic [15:0]   c_out_sad;

    sad_disp_search #(.WIN(3), .DATA_SIZE(8), .MAX_DISP(8), .DISP_THREADS(4), .EARLY_EXIT(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .win_l(win_l),
        .strip_r(strip_r), .disp_limit(disp_limit), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_disp(a_out_disp), .out_sad(a_out_sad));

    sad_disp_search #(.WIN(3), .DATA_SIZE(8), .MAX_DISP(8), .DISP_THREADS(4), .EARLY_EXIT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .win_l(win_l),
        .strip_r(strip_r), .disp_limit(disp_limit), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_disp(b_out_disp), .out_sad(b_out_sad));

    sad_disp_search u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .win_l(c_win),
        .strip_r(c_strip), .disp_limit(c_limit), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_disp(c_out_disp), .out_sad(c_out_sad));

    int L [3][3];
    int R [3][10];
    int n_vec = 0;
    int n_err = 0;
    int a_m_disp, a_m_sad, a_m_n, b_m_disp, b_m_sad, b_m_n;
    bit m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Exhaustive search over every allowed disparity; early exit shortens only the run length.
    function automatic void model(input int lim, input bit ee, output int disp, output int sad,
                                  output int n);
        int best = -1;
        int bd = 0;
        int first0 = -1;
        if (lim > 7) lim = 7;
        for (int d = 0; d <= lim; d++) begin
            int s = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += (L[r][c] > R[r][c+d]) ? L[r][c] - R[r][c+d] : R[r][c+d] - L[r][c];
            if (best < 0 || s < best) begin
                best = s;
                bd = d;
            end
            if (s == 0 && first0 < 0) first0 = d;
        end
        disp = bd;
        sad  = best;
        n    = (ee && first0 >= 0) ? first0 / 4 + 1 : lim / 4 + 1;
    endfunction

    task automatic pack(input int lim);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win_l[8*(r*3+c) +: 8] = 8'(L[r][c]);
            for (int c = 0; c < 10; c++) strip_r[8*(r*10+c) +: 8] = 8'(R[r][c]);
        end
        disp_limit = 3'(lim);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) L[r][c] = 10 * (5 + c);
            for (int c = 0; c < 10; c++) R[r][c] = 10 * c;
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) L[r][c] = v;
            for (int c = 0; c < 10; c++) R[r][c] = v;
        end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) L[r][c] = int'($urandom_range(0, 255));
            for (int c = 0; c < 10; c++) R[r][c] = int'($urandom_range(0, 255));
        end
    endtask

    // Literal arguments < 0 mean "no hand value": the model alone decides.
    task automatic run_small(input int lim, input int bp, input int lit_disp, input int lit_sad,
                             input int lit_na, input int lit_nb);
        int ka = -1;
        int kb = -1;
        logic [2:0]  hd_a, hd_b;
        logic [11:0] hs_a, hs_b;
        pack(lim);
        model(lim, 1'b0, a_m_disp, a_m_sad, a_m_n);
        model(lim, 1'b1, b_m_disp, b_m_sad, b_m_n);
        out_ready = (bp == 0);
        @(negedge clk);
        chk("a_in_ready_idle", a_in_ready, 1);
        chk("b_in_ready_idle", b_in_ready, 1);
        in_valid = 1'b1;
        m_live   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 12 && (ka < 0 || kb < 0); k++) begin
            @(posedge clk);
            #1;
            if (ka < 0 && a_out_valid) begin ka = k; hd_a = a_out_disp; hs_a = a_out_sad; end
            if (kb < 0 && b_out_valid) begin kb = k; hd_b = b_out_disp; hs_b = b_out_sad; end
        end
        chk("a_latency", ka, (lit_na >= 0) ? lit_na : a_m_n);
        chk("b_latency", kb, (lit_nb >= 0) ? lit_nb : b_m_n);
        if (lit_disp >= 0) begin
            chk("a_disp_lit", hd_a, lit_disp);
            chk("a_sad_lit", hs_a, lit_sad);
            chk("b_disp_lit", hd_b, lit_disp);
            chk("b_sad_lit", hs_b, lit_sad);
        end
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                in_valid = (i % 2 == 0);
                @(posedge clk);
                #1;
                chk("bp_a_in_ready", a_in_ready, 0);
                chk("bp_b_in_ready", b_in_ready, 0);
                chk("bp_a_valid", a_out_valid, 1);
                chk("bp_a_disp_stable", a_out_disp, hd_a);
                chk("bp_a_sad_stable", a_out_sad, hs_a);
                chk("bp_b_disp_stable", b_out_disp, hd_b);
                chk("bp_b_sad_stable", b_out_sad, hs_b);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("a_in_ready_after", a_in_ready, 1);
        chk("b_in_ready_after", b_in_ready, 1);
        chk("a_valid_dropped", a_out_valid, 0);
        chk("b_valid_dropped", b_out_valid, 0);
        m_live = 1'b0;
        @(posedge clk);
        #1;
        chk("a_stays_idle", a_out_valid, 0);
        chk("b_stays_idle", b_out_valid, 0);
    endtask

    // Result checker against the model whenever a result is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && a_out_valid) begin
                if (!m_live) chk("a_spurious_valid", a_out_valid, 0);
                else begin
                    chk("a_disp_model", a_out_disp, a_m_disp);
                    chk("a_sad_model", a_out_sad, a_m_sad);
                end
            end
            if (!rst && b_out_valid) begin
                if (!m_live) chk("b_spurious_valid", b_out_valid, 0);
                else begin
                    chk("b_disp_model", b_out_disp, b_m_disp);
                    chk("b_sad_model", b_out_sad, b_m_sad);
                end
            end
        end
    end

    initial begin
        int kc = -1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; win_l = '0; strip_r = '0; disp_limit = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_win = '0; c_strip = '0; c_limit = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_disp", a_out_disp, 0);
        chk("rst_a_sad", a_out_sad, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_b_in_ready", b_in_ready, 1);
        chk("rst_c_valid", c_out_valid, 0);
        chk("rst_c_in_ready", c_in_ready, 1);

        fill_ramp();
        run_small(7, 0, 5, 0, 2, 2);
        run_small(2, 0, 2, 270, 1, 1);
        fill_const(100);
        run_small(7, 0, 0, 0, 2, 1);
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            run_small(7 - i, 0, -1, -1, -1, -1);
        end
        fill_ramp();
        run_small(4, 5, 4, 90, 2, 2);

        // Reset arrives while the next request is still searching.
        fill_ramp();
        pack(7);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_a_valid", a_out_valid, 0);
        chk("midrst_a_disp", a_out_disp, 0);
        chk("midrst_a_sad", a_out_sad, 0);
        chk("midrst_a_in_ready", a_in_ready, 1);
        chk("midrst_b_disp", b_out_disp, 0);
        chk("midrst_b_sad", b_out_sad, 0);
        chk("midrst_b_in_ready", b_in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_result_a", a_out_valid, 0);
        chk("midrst_no_result_b", b_out_valid, 0);
        run_small(7, 0, 5, 0, 2, 2);

        // Widest SAD with default parameters: every disparity ties at the maximum.
        c_win   = '1;
        c_strip = '0;
        c_limit = '1;
        @(negedge clk);
        chk("c_in_ready_idle", c_in_ready, 1);
        c_in_valid = 1'b1;
        @(posedge clk);
        #1 c_in_valid = 1'b0;
        for (int k = 1; k <= 12 && kc < 0; k++) begin
            @(posedge clk);
            #1;
            if (c_out_valid) begin
                kc = k;
                chk("c_sad_max", c_out_sad, 57375);
                chk("c_disp_max", c_out_disp, 0);
            end
        end
        chk("c_latency", kc, 4);
        @(posedge clk);
        #1;
        chk("c_valid_dropped", c_out_valid, 0);
        chk("c_in_ready_after", c_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sad_disp_search.md
# sad_disp_search

Streaming, handshaked disparity search engine for one reference pixel per transaction. It captures a flattened left window and the matching right-image strip, then evaluates `DISP_THREADS` candidate disparities per cycle with parallel SAD units over `MAX_DISP/DISP_THREADS` groups. It returns the minimum-SAD disparity and its SAD value. The block sits between the row/window buffer and the disparity-map writer, and adds ready/valid flow control, a per-request search limit and optional early exit.

## Interface
- `WIN`, 15: window edge; window holds `WIN*WIN` pixels.
- `DATA_SIZE`, 8: bits per pixel.
- `MAX_DISP`, 64: number of candidate disparities, 0..`MAX_DISP`-1.
- `DISP_THREADS`, 16: disparities evaluated per cycle. `MAX_DISP % DISP_THREADS` must be 0.
- `EARLY_EXIT`, 0: when 1, the search stops after any group that leaves best SAD == 0.
- Derived:
  - `G = MAX_DISP/DISP_THREADS`
  - `STRIP_W = WIN+MAX_DISP-1`
  - `SAD_BITS = clog2(WIN*WIN*(2^DATA_SIZE-1)+1)`
  - `DISP_BITS = max(1, clog2(MAX_DISP))`
- Ports:
  - `clk`, in, 1: clock.
  - `rst`, in, 1: reset; synchronous, active-high.
  - `in_valid`, in, 1: request present.
  - `in_ready`, out, 1: block can accept a request.
  - `win_l`, in, `DATA_SIZE*WIN*WIN`: left window. Pixel (r,c) is at bit offset `DATA_SIZE*(r*WIN+c)`.
  - `strip_r`, in, `DATA_SIZE*WIN*STRIP_W`: right strip. Pixel (r,c) is at bit offset `DATA_SIZE*(r*STRIP_W+c)`.
  - `disp_limit`, in, `DISP_BITS`: highest disparity to evaluate; values ≥ `MAX_DISP` are treated as `MAX_DISP-1`.
  - `out_valid`, out, 1: result present.
  - `out_ready`, in, 1: consumer accepts the result.
  - `out_disp`, out, `DISP_BITS`: winning disparity.
  - `out_sad`, out, `SAD_BITS`: SAD at `out_disp`.

## Operation
- Disparity d compares `win_l` against strip columns d..d+`WIN`-1 in all rows.
  - SAD(d) = Σ |L(r,c) − R(r,c+d)|, computed unsigned at full `SAD_BITS` width, with no saturation.
- On accept (`in_valid && in_ready`), the block registers `win_l`, `strip_r` and `disp_limit`. Upstream may change its inputs afterwards.
- Group count N = floor(limit/`DISP_THREADS`)+1.
- FSM:
  - IDLE:
    - `in_ready`=1.
    - On accept: best_sad ← all ones, best_disp ← 0, group ← 0, go to SEARCH.
  - SEARCH:
    - Each cycle evaluates disparities group*`DISP_THREADS` + t, for t = 0..`DISP_THREADS`-1.
    - Disparities > limit are masked and never win.
    - Within a group, the lowest t with the minimum SAD is the candidate.
    - The candidate replaces best only if its SAD < best_sad (strict). Ties therefore always resolve to the lowest disparity.
    - After group N-1, or after any group where the updated best_sad == 0 and `EARLY_EXIT`=1: load `out_disp`/`out_sad` and go to DONE. Otherwise group increments.
  - DONE:
    - `out_valid`=1; `out_disp`/`out_sad` are held stable.
    - On `out_ready`, go to IDLE.
- `in_ready` is 0 in SEARCH and DONE. `in_valid` is ignored there and no request is queued.
- Reset, including mid-SEARCH or mid-DONE:
  - The next state is IDLE and any in-flight search is discarded.
  - `out_valid`=0, `out_disp`=0, `out_sad`=0.
  - `in_ready`=1 in the first cycle after `rst` deasserts.

## Timing
- Accept at edge T. Group k is evaluated in the cycle after edge T+k and registered at edge T+1+k.
- `out_valid` rises after edge T+N, i.e. a latency of N+1 cycles. Full search: `G`+1 cycles. Early exit after group k: k+2 cycles.
- The output handshake completes at the edge where `out_valid && out_ready`. `out_valid` drops and `in_ready` rises in the following cycle.
- Minimum request spacing: N+2 cycles.
- SAD and the per-group compare are combinational within one cycle. `out_*` are driven from registers only.

## Test plan
WIN=3, DATA_SIZE=8, MAX_DISP=8, DISP_THREADS=4 (G=2), unless stated otherwise.

- Reset:
  - Hold `rst` for 2 cycles, mid-SEARCH of a prior request → after release: `out_valid`=0, `out_disp`=0, `out_sad`=0, `in_ready`=1.
  - A fresh request then completes normally.
- Full search:
  - Stimulus: strip R(r,c)=10c, L(r,c)=10(5+c), limit=7, `EARLY_EXIT`=0.
  - Expected SAD(d)=90·|5−d|.
  - Response: `out_disp`=5, `out_sad`=0, `out_valid` at T+3.
- Limit masking:
  - Same data with limit=2 → N=1.
  - Response: `out_disp`=2, `out_sad`=270, `out_valid` at T+2.
- Ties and early exit:
  - Stimulus: all pixels 100, limit=7.
  - `EARLY_EXIT`=0 → `out_disp`=0, `out_sad`=0 at T+3.
  - `EARLY_EXIT`=1 → same result at T+2.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` and pulse `in_valid` meanwhile.
  - Response: outputs are stable, `in_ready`=0, no accept occurs.
  - On `out_ready`=1 → `in_ready`=1 next cycle.
- Width extremes:
  - Stimulus: all L=255, all R=0, WIN=15, default parameters.
  - Response: `out_sad`=57375 (fits 16 bits), `out_disp`=0.
